// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    MEAS,
    LOCKED
  } div_mon_state_t;

  typedef struct packed {
    int lo;
    int hi;
  } hi_bounds_t;

  // Acceptable sampled-high window for a given divide ratio. Odd ratios
  // allow either rounding of the half period, even ratios require exact half.
  function automatic hi_bounds_t hi_bounds(input int exp_period);
    hi_bounds_t b;
    b.lo = exp_period / 2;
    b.hi = (exp_period + 1) / 2;
    return b;
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// Two-stage sampler of the divided clock with rising-edge detect. The input
// is generated from clk, so no metastability synchronizer is needed.
module div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic div_clk_i,
  output logic d1,
  output logic rise
);

  logic d2;

  // Sample the divided clock and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= div_clk_i;
      d2 <= d1;
    end
  end

  assign rise = d1 & ~d2;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and sampled-high time of the divided clock, declares lock
// after a run of good periods, and flags mis-divided, stuck or skewed output.
//
// state  | meaning
// IDLE   | monitor disabled, counters held clear
// ACQ    | waiting for the first rising edge to start a measurement
// MEAS   | publishing measurements, counting consecutive good periods
// LOCKED | good-run target reached, any bad period drops back to MEAS
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 9,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_clk_i,
  output logic             locked,
  output logic             period_vld,
  output logic [CNT_W-1:0] period_val,
  output logic [CNT_W-1:0] high_val,
  output logic             period_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam hi_bounds_t       HI      = hi_bounds(EXP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(HI.lo);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(HI.hi);
  localparam int               GR_W    = $clog2(LOCK_CNT + 1);
  localparam logic [GR_W-1:0]  GR_LAST = GR_W'(LOCK_CNT - 1);

  div_mon_state_t   state, state_nxt;
  logic [GR_W-1:0]  good_run, good_run_nxt;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic             d1, rise;
  logic             good, timeout, pub, err;

  div_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .div_clk_i (div_clk_i),
    .d1        (d1),
    .rise      (rise)
  );

  assign good    = (pcnt == EXP_C) && (hcnt >= HI_MIN) && (hcnt <= HI_MAX);
  assign timeout = (pcnt == CNT_MAX) && !rise;
  assign locked  = (state == LOCKED);

  // Period and high-time counters restart on every rising edge and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (!en) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      pcnt <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (pcnt != CNT_MAX) pcnt <= pcnt + 1'b1;
      if (d1 && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
    end
  end

  // State and good-run registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      good_run <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
    end
  end

  // Next state, publish and error decisions; a rise beats a timeout.
  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    pub          = 1'b0;
    err          = 1'b0;
    if (!en) begin
      state_nxt    = IDLE;
      good_run_nxt = '0;
    end else begin
      case (state)
        IDLE: state_nxt = ACQ;
        ACQ: begin
          if (rise) begin
            state_nxt    = MEAS;
            good_run_nxt = '0;
          end
        end
        MEAS: begin
          if (rise) begin
            pub = 1'b1;
            if (good) begin
              good_run_nxt = good_run + 1'b1;
              if (good_run == GR_LAST) state_nxt = LOCKED;
            end else begin
              err          = 1'b1;
              good_run_nxt = '0;
            end
          end else if (timeout) begin
            err          = 1'b1;
            state_nxt    = ACQ;
            good_run_nxt = '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            pub = 1'b1;
            if (!good) begin
              err          = 1'b1;
              state_nxt    = MEAS;
              good_run_nxt = '0;
            end
          end else if (timeout) begin
            err          = 1'b1;
            state_nxt    = ACQ;
            good_run_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered measurement outputs and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_vld <= 1'b0;
      period_err <= 1'b0;
      period_val <= '0;
      high_val   <= '0;
      err_cnt    <= '0;
    end else begin
      period_vld <= pub;
      period_err <= err;
      if (pub) begin
        period_val <= pcnt;
        high_val   <= hcnt;
      end
      if (!en) err_cnt <= '0;
      else if (err && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor: two instances (ratio 9 and 8) see
// the same divided-clock waveform; a reference model derives each expected
// publication from the measured edge spacing and the programmed high time.
module tb_div_clk_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       div_clk_i = 1'b0;
  logic       locked9, vld9, err9, locked8, vld8, err8;
  logic [7:0] pval9, hval9, ecnt9, pval8, hval8, ecnt8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic        lk;
    logic [7:0]  p;
    logic [7:0]  h;
    logic [7:0]  ec;
    logic [31:0] t;
  } mon_t;

  mon_t obs0[$], obs1[$], exp0[$], exp1[$];
  mon_t m0, m1;

  bit m_acq[2];
  bit m_lk[2];
  int m_streak[2];
  int m_ec[2];
  int m_start[2];
  int m_h[2];

  div_clk_monitor #(.CNT_W(8), .EXP_PERIOD(9), .LOCK_CNT(4)) dut9 (
    .clk(clk), .rst(rst), .en(en), .div_clk_i(div_clk_i),
    .locked(locked9), .period_vld(vld9), .period_val(pval9),
    .high_val(hval9), .period_err(err9), .err_cnt(ecnt9)
  );

  div_clk_monitor #(.CNT_W(8), .EXP_PERIOD(8), .LOCK_CNT(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .div_clk_i(div_clk_i),
    .locked(locked8), .period_vld(vld8), .period_val(pval8),
    .high_val(hval8), .period_err(err8), .err_cnt(ecnt8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse seen on either instance, stamped with its cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld9 || err9) begin
        m0 = '{vld9, err9, locked9, vld9 ? pval9 : 8'd0, vld9 ? hval9 : 8'd0, ecnt9, 32'(cyc)};
        obs0.push_back(m0);
      end
      if (vld8 || err8) begin
        m1 = '{vld8, err8, locked8, vld8 ? pval8 : 8'd0, vld8 ? hval8 : 8'd0, ecnt8, 32'(cyc)};
        obs1.push_back(m1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acq[i] = 0; m_lk[i] = 0; m_streak[i] = 0; m_ec[i] = 0; m_start[i] = 0; m_h[i] = 0;
    end
  endtask

  // A rising edge sampled in cycle rc closes the period that began at the
  // previous edge; h_new is the high time of the period it opens.
  task automatic model_rise(input int i, input int rc, input int h_new);
    int  e, p;
    bit  ok;
    mon_t m;
    e = (i == 0) ? 9 : 8;
    if (m_acq[i]) begin
      p = rc - m_start[i];
      if (p > 255) begin
        m_lk[i] = 0; m_streak[i] = 0;
        if (m_ec[i] < 255) m_ec[i]++;
        m = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'(m_ec[i]), 32'(m_start[i] + 256)};
      end else begin
        ok = (p == e) && (m_h[i] >= e / 2) && (m_h[i] <= (e + 1) / 2);
        if (ok) begin
          m_streak[i]++;
          if (m_streak[i] >= 4) m_lk[i] = 1;
        end else begin
          m_streak[i] = 0; m_lk[i] = 0;
          if (m_ec[i] < 255) m_ec[i]++;
        end
        m = '{1'b1, !ok, m_lk[i], 8'(p), 8'(m_h[i]), 8'(m_ec[i]), 32'(rc + 1)};
      end
      if (i == 0) exp0.push_back(m); else exp1.push_back(m);
    end
    m_acq[i] = 1; m_start[i] = rc; m_h[i] = h_new;
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input logic v);
    @(posedge clk);
    #(1 + $urandom_range(0, 5));
    div_clk_i = v;
  endtask

  task automatic edge_rise(input int h);
    int rc;
    step(1'b1);
    rc = cyc + 1;
    model_rise(0, rc, h);
    model_rise(1, rc, h);
  endtask

  task automatic drive_period(input int p, input int h);
    edge_rise(h);
    for (int i = 1; i < p; i++) step(i < h);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_clk_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vld9 !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", vld9); end
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err9); end
    checks++; if (locked9 !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked9); end
    checks++; if (pval9 !== 8'd0) begin failures++; $display("FAIL reset_pval got=%0d want=0", pval9); end
    checks++; if (hval9 !== 8'd0) begin failures++; $display("FAIL reset_hval got=%0d want=0", hval9); end
    checks++; if (ecnt9 !== 8'd0) begin failures++; $display("FAIL reset_ecnt got=%0d want=0", ecnt9); end
    checks++; if ({locked8, vld8, err8, ecnt8} !== 11'd0) begin failures++; $display("FAIL reset_dut8 got=%h want=0", {locked8, vld8, err8, ecnt8}); end
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1;
    model_clear();
  endtask

  task automatic test_lock();
    repeat (3) step(1'b0);
    for (int k = 0; k < 6; k++) drive_period(9, 4 + $urandom_range(0, 1));
    drive_period(10, 5);
    for (int k = 0; k < 6; k++) drive_period(9, 4 + $urandom_range(0, 1));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (locked9 !== m_lk[0]) begin failures++; $display("FAIL lock_final got=%b want=%b", locked9, m_lk[0]); end
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL lock_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL lock_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_duty();
    drive_period(10, 5);
    drive_period(9, 4);
    drive_period(9, 5);
    drive_period(9, 2);
    for (int k = 0; k < 6; k++) drive_period(9, 4 + $urandom_range(0, 1));
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL duty_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL duty_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_stuck();
    for (int k = 0; k < 5; k++) drive_period(9, 4);
    drive_period(300, 1);
    drive_period(255, 3);
    drive_period(256, 3);
    for (int k = 0; k < 3; k++) drive_period(9, 5);
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL stuck_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL stuck_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_en_drop();
    for (int k = 0; k < 6; k++) drive_period(9, 4);
    drive_period(10, 4);
    for (int k = 0; k < 5; k++) drive_period(9, 4);
    edge_rise(4);
    step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    #1;
    checks++;
    if (locked9 !== m_lk[0]) begin failures++; $display("FAIL en_prelock got=%b want=%b", locked9, m_lk[0]); end
    @(posedge clk);
    #1;
    en = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    checks++; if (locked9 !== 1'b0) begin failures++; $display("FAIL en_locked got=%b want=0", locked9); end
    checks++; if (ecnt9 !== 8'd0) begin failures++; $display("FAIL en_errcnt got=%0d want=0", ecnt9); end
    checks++; if ({locked8, ecnt8} !== 9'd0) begin failures++; $display("FAIL en_dut8 got=%h want=0", {locked8, ecnt8}); end
    checks++; if ({vld9, err9, vld8, err8} !== 4'd0) begin failures++; $display("FAIL en_pulses got=%b want=0", {vld9, err9, vld8, err8}); end
    repeat (4) step(1'b0);
    @(posedge clk);
    #1;
    en = 1'b1;
    repeat (3) step(1'b0);
    for (int k = 0; k < 6; k++) drive_period(9, 5);
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL en_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL en_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_exp8();
    for (int k = 0; k < 6; k++) drive_period(8, 4);
    drive_period(8, 3);
    drive_period(8, 5);
    for (int k = 0; k < 6; k++) drive_period(8, 4);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (locked8 !== m_lk[1]) begin failures++; $display("FAIL exp8_locked got=%b want=%b", locked8, m_lk[1]); end
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL exp8_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL exp8_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_random();
    int p, h;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) p = $urandom_range(6, 11);
      else p = ($urandom_range(0, 1) != 0) ? 9 : 8;
      if ($urandom_range(0, 4) == 0) h = $urandom_range(1, p - 1);
      else h = p / 2 + $urandom_range(0, p % 2);
      drive_period(p, h);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL rand_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL rand_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_err_sat();
    for (int k = 0; k < 262; k++) drive_period(3, 1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ecnt9 !== 8'd255) begin failures++; $display("FAIL sat_errcnt got=%0d want=255", ecnt9); end
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL sat_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL sat_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  task automatic test_rst_mid();
    bit found;
    for (int k = 0; k < 5; k++) drive_period(9, 4);
    edge_rise(5);
    found = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (vld9) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rst_wait_vld got=0 want=1 within 6 cycles"); end
    #1;
    rst = 1'b1;
    div_clk_i = 1'b0;
    #1;
    checks++; if ({vld9, err9, locked9} !== 3'd0) begin failures++; $display("FAIL rst_flags got=%b want=000", {vld9, err9, locked9}); end
    checks++; if ({pval9, hval9, ecnt9} !== 24'd0) begin failures++; $display("FAIL rst_values got=%h want=0", {pval9, hval9, ecnt9}); end
    checks++; if ({vld8, err8, locked8, pval8, hval8, ecnt8} !== 27'd0) begin failures++; $display("FAIL rst_dut8 got=%h want=0", {vld8, err8, locked8, pval8, hval8, ecnt8}); end
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL rst_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL rst_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1'b0);
    for (int k = 0; k < 6; k++) drive_period(9, 4 + $urandom_range(0, 1));
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_t eq[$], oq[$];
      if (i == 0) begin eq = exp0; oq = obs0; exp0.delete(); obs0.delete(); end
      else begin eq = exp1; oq = obs1; exp1.delete(); obs1.delete(); end
      checks++;
      if (oq.size() != eq.size()) begin failures++; $display("FAIL rst_after_count inst%0d got=%0d want=%0d", i, oq.size(), eq.size()); end
      for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
        checks++;
        if (oq[j] !== eq[j]) begin failures++; $display("FAIL rst_after_pub inst%0d #%0d got=%h want=%h", i, j, oq[j], eq[j]); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_lock();
    test_duty();
    test_stuck();
    test_en_drop();
    test_exp8();
    test_random();
    test_err_sat();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
